coin_collector: RTL
===================

// Module: coin_collector
// PURPOSE
//  Upstream front end of the metro ticket machine. Accepts coins and notes one at a time,
//  accumulates the inserted amount, and on passenger confirm hands it downstream as
//  Input_money with a one-cycle transaction pulse. Holds the amount until the ticketing
//  core raises done. Returns the full amount on cancel and rejects deposits that overflow.
// PARAMETERS
//  MAX_AMOUNT      200  largest accumulable total in rupees; must be <= 255
//  TIMEOUT_CYCLES  1000 idle cycles in COLLECT before auto-cancel (COIN_TIMEOUT_EN only)
// PORTS
//  clk          in   1  system clock, rising edge
//  arstn        in   1  asynchronous active-low reset
//  coin_valid   in   1  one-cycle strobe: a deposit is present
//  coin_type    in   2  0=Rs5 1=Rs10 2=Rs20 3=Rs50; sampled with coin_valid
//  confirm      in   1  passenger confirm (level, acted on once per commit)
//  cancel       in   1  passenger cancel
//  done         in   1  ticketing core finished this transaction
//  Input_money  out  8  committed amount; stable from the transaction pulse until done
//  transaction  out  1  one-cycle commit pulse to the ticketing core
//  total        out  8  running amount for the display
//  coin_reject  out  1  one-cycle pulse: deposit returned to the chute
//  refund_valid out  1  one-cycle pulse: refund_amt is valid
//  refund_amt   out  8  amount refunded on cancel or timeout
// BEHAVIOUR
//  - Reset: all outputs and the accumulator are 0, state is IDLE. Reset mid-operation
//    discards the total with no refund pulse.
//  - All outputs are registered. Every response appears in the cycle after the sampling edge.
//  - States:
//    IDLE      -> COLLECT   on an accepted coin
//    COLLECT   -> COMMIT    on confirm with total>0
//    COLLECT   -> REFUND    on cancel
//    COMMIT    -> WAIT_DONE (1 cycle; transaction=1, Input_money=total)
//    WAIT_DONE -> IDLE      on done; total and Input_money cleared
//    REFUND    -> IDLE      (1 cycle; refund_valid=1, refund_amt=total, then total cleared)
//  - Deposits are accepted only in IDLE and COLLECT. The accept test is done in 9 bits:
//    total+value <= MAX_AMOUNT. Otherwise coin_reject pulses and total is unchanged.
//  - A coin in COMMIT, WAIT_DONE or REFUND is always rejected.
//  - coin_valid together with confirm in COLLECT: the coin is added first, and the commit
//    carries the new sum. If that coin is rejected, the commit uses the old total.
//  - cancel together with confirm: cancel wins.
//  - coin_valid together with cancel: the coin is rejected and the refund excludes it.
//  - confirm or cancel in IDLE is ignored. done outside WAIT_DONE is ignored.
//  - WAIT_DONE waits indefinitely. cancel there is ignored, because the money is already
//    committed.
// CONFIGURATION
//  COIN_TIMEOUT_EN defined:
//    - A counter runs in COLLECT and clears on every accepted coin.
//    - After TIMEOUT_CYCLES cycles with no accepted coin, the block enters REFUND exactly
//      as if cancel had been asserted.
//  COIN_TIMEOUT_EN undefined: no counter; COLLECT waits indefinitely.
// STRUCTURE
//  metro_pkg:
//    - coin_e enum (RS5, RS10, RS20, RS50)
//    - coin_value(coin_e) function returning 8-bit rupees
//    - collector_state_e enum
//    - MONEY_W=8 constant
//  Sub-module coin_idle_timer (clk, arstn, run, clear, expired):
//    - instantiated only under COIN_TIMEOUT_EN
//    - FSM and accumulator stay in coin_collector
// TESTING
//  1. Rs50 + Rs50, then confirm
//       -> transaction pulses one cycle with Input_money=100
//       -> Input_money holds 100 until done, then everything is 0.
//  2. Deposit Rs50 x4 (total 200), then Rs5
//       -> coin_reject pulses and total stays 200.
//     Then confirm -> Input_money=200.
//  3. Rs20 + Rs10, then cancel
//       -> refund_valid one cycle, refund_amt=30, then total=0 and state IDLE
//       -> no transaction pulse.
//  4. In COLLECT with total 10: Rs20 strobed together with confirm -> Input_money=30.
//     Repeat with cancel+confirm+coin -> refund_amt=10 and coin_reject=1.
//  5. During WAIT_DONE: coin -> reject; cancel -> ignored; confirm -> no second transaction.
//     Then done -> IDLE.
//  6. COIN_TIMEOUT_EN with TIMEOUT_CYCLES=8: Rs10, then idle for 8 cycles
//       -> refund_amt=10.
//     Pulse arstn mid-COLLECT -> all outputs 0 immediately, no refund pulse.

Source files
------------

// File: rtl/metro_pkg.sv
// Shared types for the metro ticket machine front end: coin encodings,
// collector FSM states and the money width.
package metro_pkg;

    localparam int MONEY_W = 8;

    typedef enum logic [1:0] {
        RS5  = 2'd0,
        RS10 = 2'd1,
        RS20 = 2'd2,
        RS50 = 2'd3
    } coin_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COLLECT   = 3'd1,
        ST_COMMIT    = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_REFUND    = 3'd4
    } collector_state_e;

    function automatic logic [MONEY_W-1:0] coin_value(coin_e c);
        case (c)
            RS5:     return 8'd5;
            RS10:    return 8'd10;
            RS20:    return 8'd20;
            default: return 8'd50;
        endcase
    endfunction

endpackage

// File: rtl/coin_idle_timer.sv
// Idle counter for COLLECT: counts cycles while run is high, restarts on clear,
// and flags expired on the CYCLES-th consecutive idle cycle.
module coin_idle_timer #(
    parameter int CYCLES = 1000
) (
    input  logic clk,
    input  logic arstn,
    input  logic run,
    input  logic clear,
    output logic expired
);
    localparam int CW = $clog2(CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // expired depends only on the count, never on clear, so the accept logic
    // in the collector can use it without forming a combinational loop
    assign expired = run && (cnt_q == CW'(CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear || !run)
            cnt_d = '0;
        else if (!expired)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/coin_collector.sv
// Coin/note accumulator feeding the ticketing core. Optional idle auto-cancel
// is built when COIN_TIMEOUT_EN is defined.
module coin_collector
    import metro_pkg::*;
#(
    parameter int MAX_AMOUNT     = 200,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       arstn,
    input  logic       coin_valid,
    input  logic [1:0] coin_type,
    input  logic       confirm,
    input  logic       cancel,
    input  logic       done,
    output logic [7:0] Input_money,
    output logic       transaction,
    output logic [7:0] total,
    output logic       coin_reject,
    output logic       refund_valid,
    output logic [7:0] refund_amt
);
    collector_state_e     state_q, state_d;
    logic [MONEY_W-1:0]   total_q, total_d;
    logic [MONEY_W-1:0]   money_q, money_d;
    logic [MONEY_W-1:0]   refund_amt_q, refund_amt_d;
    logic                 transaction_q, transaction_d;
    logic                 coin_reject_q, coin_reject_d;
    logic                 refund_valid_q, refund_valid_d;

    logic [MONEY_W-1:0]   value;
    logic [MONEY_W:0]     sum;
    logic [MONEY_W-1:0]   total_acc;
    logic                 fits, abort, accept, timer_expired;

`ifdef COIN_TIMEOUT_EN
    coin_idle_timer #(.CYCLES(TIMEOUT_CYCLES)) u_idle_timer (
        .clk     (clk),
        .arstn   (arstn),
        .run     (state_q == ST_COLLECT),
        .clear   (accept),
        .expired (timer_expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign timer_expired  = 1'b0;
`endif

    // Overflow test in 9 bits so 250+50 cannot wrap into an accept
    assign value     = coin_value(coin_e'(coin_type));
    assign sum       = {1'b0, total_q} + {1'b0, value};
    assign fits      = sum <= (MONEY_W+1)'(MAX_AMOUNT);
    assign abort     = (state_q == ST_COLLECT) && (cancel || timer_expired);
    assign accept    = coin_valid && fits &&
                       ((state_q == ST_IDLE) || (state_q == ST_COLLECT && !abort));
    assign total_acc = accept ? sum[MONEY_W-1:0] : total_q;

    always_comb begin
        state_d        = state_q;
        total_d        = total_acc;
        money_d        = money_q;
        transaction_d  = 1'b0;
        coin_reject_d  = coin_valid && !accept;
        refund_valid_d = 1'b0;
        refund_amt_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept)
                    state_d = ST_COLLECT;
            end
            ST_COLLECT: begin
                // cancel beats confirm; a same-cycle coin is already excluded by accept
                if (abort) begin
                    state_d        = ST_REFUND;
                    refund_valid_d = 1'b1;
                    refund_amt_d   = total_q;
                end else if (confirm && total_acc != '0) begin
                    state_d       = ST_COMMIT;
                    transaction_d = 1'b1;
                    money_d       = total_acc;
                end
            end
            ST_COMMIT: state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (done) begin
                    state_d = ST_IDLE;
                    total_d = '0;
                    money_d = '0;
                end
            end
            ST_REFUND: begin
                state_d = ST_IDLE;
                total_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q        <= ST_IDLE;
            total_q        <= '0;
            money_q        <= '0;
            transaction_q  <= 1'b0;
            coin_reject_q  <= 1'b0;
            refund_valid_q <= 1'b0;
            refund_amt_q   <= '0;
        end else begin
            state_q        <= state_d;
            total_q        <= total_d;
            money_q        <= money_d;
            transaction_q  <= transaction_d;
            coin_reject_q  <= coin_reject_d;
            refund_valid_q <= refund_valid_d;
            refund_amt_q   <= refund_amt_d;
        end
    end

    assign Input_money  = money_q;
    assign transaction  = transaction_q;
    assign total        = total_q;
    assign coin_reject  = coin_reject_q;
    assign refund_valid = refund_valid_q;
    assign refund_amt   = refund_amt_q;

endmodule
